// File: rtl/dest_scoreboard_pkg.sv
// Shared constants and types for the destination-register scoreboard.
// Register-file shape, well-known register indices, default counter width.
// Configuration macro used by the scoreboard: SCOREBOARD_BYPASS_EN.
package dest_scoreboard_pkg;
   localparam int NUM_REGS   = 32;
   localparam int REG_W      = 5;
   localparam int CNT_W      = 2;
   localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
   localparam logic [REG_W-1:0] REG_STATUS = 5'd30;
   localparam logic [REG_W-1:0] REG_RA     = 5'd31;

   typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/dest_scoreboard_if.sv
// Issue/retire/hazard bundle between decode and the destination scoreboard.
// master: decode side (drives issue, sources, retire; observes stall/ready/pending).
// slave : scoreboard side (the reverse).
interface dest_scoreboard_if #(
   parameter int NUM_REGS = dest_scoreboard_pkg::NUM_REGS
);
   import dest_scoreboard_pkg::*;

   logic                issue_valid;
   reg_idx_t            issue_rd;
   logic                issue_ready;
   reg_idx_t            rs1;
   reg_idx_t            rs2;
   logic                retire_valid;
   reg_idx_t            retire_rd;
   logic                stall;
   logic [NUM_REGS-1:0] pending;
   logic                underflow_err;

   modport master (
      output issue_valid, issue_rd, rs1, rs2, retire_valid, retire_rd,
      input  issue_ready, stall, pending, underflow_err
   );

   modport slave (
      input  issue_valid, issue_rd, rs1, rs2, retire_valid, retire_rd,
      output issue_ready, stall, pending, underflow_err
   );
endinterface

// File: rtl/dest_scoreboard_sb_counter.sv
// sb_counter: saturating in-flight write counter for one register.
// Latency: count updates on the edge after inc/dec; at_max/is_zero are decoded from the flop.
// Ports: clock, reset (sync, active-high), inc, dec -> count, at_max, is_zero. No wrap either way.
module sb_counter
   import dest_scoreboard_pkg::*;
#(
   parameter int CNT_W = dest_scoreboard_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             at_max,
   output logic             is_zero
);
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign count   = count_q;
   assign at_max  = (count_q == {CNT_W{1'b1}});
   assign is_zero = (count_q == '0);

   // Simultaneous inc and dec cancel; each direction saturates on its own.
   always_comb begin
      count_d = count_q;
      if (inc && !dec && !at_max) begin
         count_d = count_q + CNT_W'(1);
      end else if (dec && !inc && !is_zero) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/dest_scoreboard.sv
// dest_scoreboard: per-register in-flight write counters producing RAW stall and issue_ready.
// Latency: stall/issue_ready combinational from state; accepted issue shows in pending/stall 1 cycle later.
// Backpressure: issue_ready drops on source hazard or destination counter full. Ports: clock, reset, sb (slave).
// SCOREBOARD_BYPASS_EN: a source being retired this cycle with count 1 does not stall (writeback forwarding).
module dest_scoreboard #(
   parameter int CNT_W    = dest_scoreboard_pkg::CNT_W,
   parameter int NUM_REGS = dest_scoreboard_pkg::NUM_REGS
) (
   input  logic              clock,
   input  logic              reset,
   dest_scoreboard_if.slave  sb
);
   import dest_scoreboard_pkg::*;

   logic [CNT_W-1:0]    count [NUM_REGS];
   logic [NUM_REGS-1:0] at_max;
   logic [NUM_REGS-1:0] is_zero;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] pending;
   logic                rs1_busy;
   logic                rs2_busy;
   logic                stall;
   logic                issue_acc;
   logic                underflow_q;
   logic                underflow_d;

   // Register 0 is hard-wired empty: never counts, never hazards.
   assign count[0]   = '0;
   assign at_max[0]  = 1'b0;
   assign is_zero[0] = 1'b1;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clock   (clock),
         .reset   (reset),
         .inc     (inc_vec[i]),
         .dec     (dec_vec[i]),
         .count   (count[i]),
         .at_max  (at_max[i]),
         .is_zero (is_zero[i])
      );
   end

   always_comb begin
      rs1_busy = (sb.rs1 != REG_ZERO) && !is_zero[sb.rs1];
      rs2_busy = (sb.rs2 != REG_ZERO) && !is_zero[sb.rs2];
`ifdef SCOREBOARD_BYPASS_EN
      // The last outstanding write lands this cycle, so the value can be forwarded.
      if (sb.retire_valid && (sb.retire_rd == sb.rs1) && (count[sb.rs1] == CNT_W'(1))) begin
         rs1_busy = 1'b0;
      end
      if (sb.retire_valid && (sb.retire_rd == sb.rs2) && (count[sb.rs2] == CNT_W'(1))) begin
         rs2_busy = 1'b0;
      end
`endif
      stall = rs1_busy || rs2_busy;
   end

   assign sb.stall       = stall;
   assign sb.issue_ready = !stall && !at_max[sb.issue_rd];
   assign issue_acc      = sb.issue_valid && sb.issue_ready;

   // One-hot strobes; bit 0 masked so register 0 traffic is dropped.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_acc) begin
         inc_vec = NUM_REGS'(1) << sb.issue_rd;
      end
      if (sb.retire_valid) begin
         dec_vec = NUM_REGS'(1) << sb.retire_rd;
      end
      inc_vec[0] = 1'b0;
      dec_vec[0] = 1'b0;
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         pending[i] = (count[i] != '0);
      end
   end

   assign sb.pending = pending;

   // Sticky: a writeback with nothing outstanding means upstream lost track.
   always_comb begin
      underflow_d = underflow_q;
      if (sb.retire_valid && (sb.retire_rd != REG_ZERO) && is_zero[sb.retire_rd]) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= underflow_d;
      end
   end

   assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_dest_scoreboard.sv
// Self-checking bench for dest_scoreboard: directed scenarios then randomized traffic,
// every cycle compared against a count-per-register reference model.
module tb_dest_scoreboard;
   localparam int NR   = 32;
   localparam int MAXC = 3;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   cnt [NR];
   bit   m_uf;
   logic g_stall;
   logic g_ready;

   dest_scoreboard_if ifc ();

   dest_scoreboard dut (
      .clock (clock),
      .reset (reset),
      .sb    (ifc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_busy(input int rs, input bit rv, input int rrd);
      bit b;
      b = (rs != 0) && (cnt[rs] != 0);
`ifdef SCOREBOARD_BYPASS_EN
      if (rv && rrd == rs && cnt[rs] == 1) b = 0;
`endif
      return b;
   endfunction

   function automatic logic [NR-1:0] m_pending();
      logic [NR-1:0] p;
      p = '0;
      for (int i = 0; i < NR; i++) p[i] = (cnt[i] != 0);
      return p;
   endfunction

   // One clock cycle: drive, compare combinational and state outputs, advance model.
   task automatic step(input bit rst, input bit iv, input int ird, input int r1,
                       input int r2, input bit rv, input int rrd);
      bit e_stall, e_ready, acc, ret;
      @(negedge clock);
      reset            = rst;
      ifc.issue_valid  = iv;
      ifc.issue_rd     = 5'(ird);
      ifc.rs1          = 5'(r1);
      ifc.rs2          = 5'(r2);
      ifc.retire_valid = rv;
      ifc.retire_rd    = 5'(rrd);
      #1;
      e_stall = m_busy(r1, rv, rrd) || m_busy(r2, rv, rrd);
      e_ready = !e_stall && (cnt[ird] != MAXC);
      g_stall = ifc.stall;
      g_ready = ifc.issue_ready;
      chk("stall", 64'(ifc.stall), 64'(e_stall));
      chk("issue_ready", 64'(ifc.issue_ready), 64'(e_ready));
      chk("pending", 64'(ifc.pending), 64'(m_pending()));
      chk("underflow_err", 64'(ifc.underflow_err), 64'(m_uf));
      @(posedge clock);
      if (rst) begin
         for (int i = 0; i < NR; i++) cnt[i] = 0;
         m_uf = 0;
      end else begin
         acc = iv && e_ready && ird != 0;
         ret = rv && rrd != 0;
         if (ret && cnt[rrd] == 0) m_uf = 1;
         if (!(acc && ret && ird == rrd)) begin
            if (acc) cnt[ird]++;
            if (ret && cnt[rrd] > 0) cnt[rrd]--;
         end
      end
   endtask

   initial begin
      int iv, ird, r1, r2, rv, rrd;
      int pool [10] = '{0, 1, 2, 3, 5, 6, 7, 9, 30, 31};
      n_cmp = 0;
      n_err = 0;
      m_uf  = 0;
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      reset = 1'b1;
      ifc.issue_valid = 0; ifc.issue_rd = 0; ifc.rs1 = 0; ifc.rs2 = 0;
      ifc.retire_valid = 0; ifc.retire_rd = 0;
      repeat (2) @(posedge clock);

      // Reset state: nothing pending, ready for every destination.
      for (int r = 0; r < NR; r++) step(0, 0, r, 0, 0, 0, 0);

      // rd=31 round trip with dependent source.
      step(0, 1, 31, 0, 0, 0, 0);
      #1 chk("ra_pending_up", 64'(ifc.pending[31]), 64'd1);
      step(0, 0, 0, 31, 0, 0, 0);
      chk("ra_stall", 64'(g_stall), 64'd1);
      step(0, 0, 0, 0, 0, 1, 31);
      #1 chk("ra_pending_down", 64'(ifc.pending[31]), 64'd0);

      // Counter full on rd=5; rd=6 still accepted.
      repeat (3) step(0, 1, 5, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0, 0, 0);
      chk("rd5_full_ready", 64'(g_ready), 64'd0);
      step(0, 1, 6, 0, 0, 0, 0);
      chk("rd6_ready", 64'(g_ready), 64'd1);
      #1 chk("rd6_pending", 64'(ifc.pending[6]), 64'd1);

      // Same-cycle issue and retire of rd=7 holds the count.
      step(0, 1, 7, 0, 0, 0, 0);
      step(0, 1, 7, 0, 0, 1, 7);
      #1 chk("rd7_hold", 64'(ifc.pending[7]), 64'd1);
      step(0, 0, 0, 0, 0, 1, 7);
      #1 chk("rd7_drain", 64'(ifc.pending[7]), 64'd0);

      // Underflow is sticky until reset; reset discards pending writes.
      step(0, 0, 0, 0, 0, 1, 9);
      #1 chk("uf_set", 64'(ifc.underflow_err), 64'd1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 12, 0, 0, 1, 5);
      #1 chk("uf_reset", 64'(ifc.underflow_err), 64'd0);
      chk("reset_pending", 64'(ifc.pending), 64'd0);
      step(0, 0, 0, 0, 0, 1, 5);
      #1 chk("uf_after_discard", 64'(ifc.underflow_err), 64'd1);
      step(1, 0, 0, 0, 0, 0, 0);

      // Register 0 never becomes pending nor stalls.
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      #1 chk("r0_pending", 64'(ifc.pending[0]), 64'd0);
      chk("r0_stall", 64'(ifc.stall), 64'd0);

      // Forwarding case on rd=30 via rs2.
      step(0, 1, 30, 0, 0, 0, 0);
      step(0, 0, 0, 0, 30, 1, 30);
`ifdef SCOREBOARD_BYPASS_EN
      chk("bypass_stall", 64'(g_stall), 64'd0);
`else
      chk("bypass_stall", 64'(g_stall), 64'd1);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         iv  = ($urandom_range(99) < 60) ? 1 : 0;
         ird = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : pool[$urandom_range(9)];
         r1  = pool[$urandom_range(9)];
         r2  = ($urandom_range(1) == 0) ? 0 : pool[$urandom_range(9)];
         rv  = ($urandom_range(99) < 45) ? 1 : 0;
         rrd = pool[$urandom_range(9)];
         step(($urandom_range(299) == 0) ? 1'b1 : 1'b0, iv[0], ird, r1, r2, rv[0], rrd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
